// File: rtl/delay_match_prog_if.sv
// Bundle of per-channel request, configuration and status signals
// for the programmable delay-match block.
interface delay_match_prog_if #(
    parameter int CH = 4,
    parameter int DW = 4
);
    logic [CH-1:0]    req_in;
    logic [CH*DW-1:0] cfg_dly;
    logic [CH-1:0]    cfg_mode;
    logic [CH-1:0]    ovf_clr;
    logic [CH-1:0]    req_out;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    ovf;

    modport master (
        output req_in, cfg_dly, cfg_mode, ovf_clr,
        input  req_out, busy, ovf
    );

    modport slave (
        input  req_in, cfg_dly, cfg_mode, ovf_clr,
        output req_out, busy, ovf
    );
endinterface

// File: rtl/delay_match_prog.sv
// Clocked programmable matched-delay: each channel replays request
// transitions after cfg_dly+1 cycles, in level or pulse mode.
module delay_match_prog #(
    parameter int CH          = 4,
    parameter int DW          = 4,
    parameter int SYNC_STAGES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    delay_match_prog_if.slave bus
);
    typedef enum logic {S_IDLE, S_COUNT} st_t;

    logic [CH-1:0] w_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = bus.req_in;
        end else begin : g_sync
            logic [CH-1:0] r_sy [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++)
                        r_sy[k] <= '0;
                end else begin
                    r_sy[0] <= bus.req_in;
                    for (int k = 1; k < SYNC_STAGES; k++)
                        r_sy[k] <= r_sy[k-1];
                end
            end
            assign w_s = r_sy[SYNC_STAGES-1];
        end
    endgenerate

    st_t           r_st  [CH];
    st_t           w_st  [CH];
    logic [DW-1:0] r_cnt [CH];
    logic [DW-1:0] w_cnt [CH];
    logic [CH-1:0] r_trk, w_trk;
    logic [CH-1:0] r_mode, w_mode;
    logic [CH-1:0] r_out, w_out;
    logic [CH-1:0] r_pls, w_pls;
    logic [CH-1:0] r_ovf, w_ovf;
    logic [CH-1:0] w_busy;

    always_comb begin
        w_st   = r_st;
        w_cnt  = r_cnt;
        w_trk  = r_trk;
        w_mode = r_mode;
        w_pls  = '0;
        w_out  = r_out;
        w_ovf  = r_ovf;
        w_busy = '0;
        for (int i = 0; i < CH; i++) begin
            // a pulse-mode output lasts exactly one cycle
            if (r_pls[i])
                w_out[i] = 1'b0;
            w_ovf[i] = r_ovf[i] & ~bus.ovf_clr[i];
            case (r_st[i])
                S_IDLE: begin
                    if (w_s[i] != r_trk[i]) begin
                        w_trk[i]  = w_s[i];
                        w_cnt[i]  = bus.cfg_dly[i*DW +: DW];
                        w_mode[i] = bus.cfg_mode[i];
                        w_st[i]   = S_COUNT;
                    end
                end
                S_COUNT: begin
                    w_busy[i] = 1'b1;
                    if (r_cnt[i] != '0) begin
                        w_cnt[i] = r_cnt[i] - 1'b1;
                        if (w_s[i] != r_trk[i])
                            w_ovf[i] = 1'b1;
                    end else begin
                        w_out[i] = r_trk[i];
                        w_pls[i] = r_mode[i] & r_trk[i];
                        if (w_s[i] != r_trk[i]) begin
                            w_trk[i]  = w_s[i];
                            w_cnt[i]  = bus.cfg_dly[i*DW +: DW];
                            w_mode[i] = bus.cfg_mode[i];
                        end else begin
                            w_st[i] = S_IDLE;
                        end
                    end
                end
                default: w_st[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_st[i]  <= S_IDLE;
                r_cnt[i] <= '0;
            end
            r_trk  <= '0;
            r_mode <= '0;
            r_out  <= '0;
            r_pls  <= '0;
            r_ovf  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_st[i]  <= w_st[i];
                r_cnt[i] <= w_cnt[i];
            end
            r_trk  <= w_trk;
            r_mode <= w_mode;
            r_out  <= w_out;
            r_pls  <= w_pls;
            r_ovf  <= w_ovf;
        end
    end

    assign bus.req_out = r_out;
    assign bus.busy    = w_busy;
    assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_delay_match_prog.sv
// Bench for delay_match_prog: scoreboarded output edges plus
// direct checks of busy/ovf and a synchronised instance.
module tb_delay_match_prog;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_match_prog_if #(.CH(4), .DW(4)) ifa ();
    delay_match_prog_if #(.CH(4), .DW(4)) ifb ();

    delay_match_prog #(.CH(4), .DW(4), .SYNC_STAGES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
    );
    delay_match_prog #(.CH(4), .DW(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_nb), .bus(ifb.slave)
    );

    typedef struct {
        logic val;
        int   at;
    } ev_t;

    ev_t        q [4][$];
    logic [3:0] prev = 4'h0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(int c, logic v, int at);
        ev_t e;
        e.val = v;
        e.at  = at;
        q[c].push_back(e);
    endtask

    task automatic wait_n(int n);
        repeat (n) @(negedge clk);
    endtask

    // scoreboard: every req_out edge on dut_a must match the queue head
    always @(negedge clk) begin
        ev_t e;
        for (int c = 0; c < 4; c++) begin
            if (ifa.req_out[c] !== prev[c]) begin
                n_cmp++;
                if (q[c].size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected ch%0d @cyc %0d: got %0b want none",
                             c, cyc, ifa.req_out[c]);
                end else begin
                    e = q[c].pop_front();
                    if (e.val !== ifa.req_out[c] || e.at != cyc) begin
                        n_err++;
                        $display("FAIL sb_edge ch%0d: got %0b@%0d want %0b@%0d",
                                 c, ifa.req_out[c], cyc, e.val, e.at);
                    end
                end
            end
        end
        prev = ifa.req_out;
    end

    typedef struct {
        int ch;
        int dly;
        bit mode;
        int hold;
        int lat;
        bit pulse;
    } vec_t;

    vec_t vt [5];

    initial begin
        int k;
        vt[0] = '{ch: 0, dly: 0,  mode: 0, hold: 5,  lat: 1,  pulse: 0};
        vt[1] = '{ch: 0, dly: 1,  mode: 0, hold: 5,  lat: 2,  pulse: 0};
        vt[2] = '{ch: 0, dly: 7,  mode: 0, hold: 12, lat: 8,  pulse: 0};
        vt[3] = '{ch: 0, dly: 15, mode: 0, hold: 20, lat: 16, pulse: 0};
        vt[4] = '{ch: 1, dly: 2,  mode: 1, hold: 10, lat: 3,  pulse: 1};

        rst_n  = 1'b0;
        rst_nb = 1'b0;
        ifa.req_in   = 4'hF;
        ifa.cfg_dly  = 16'h3333;
        ifa.cfg_mode = 4'h0;
        ifa.ovf_clr  = 4'h0;
        ifb.req_in   = 4'h0;
        ifb.cfg_dly  = 16'h0003;
        ifb.cfg_mode = 4'h0;
        ifb.ovf_clr  = 4'h0;

        // reset held with requests high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_req_out", 32'(ifa.req_out), 32'h0);
            chk("rst_busy", 32'(ifa.busy), 32'h0);
            chk("rst_ovf", 32'(ifa.ovf), 32'h0);
        end
        rst_n  = 1'b1;
        rst_nb = 1'b1;
        k = cyc;
        for (int c = 0; c < 4; c++) push(c, 1'b1, k + 5);
        @(negedge clk);
        chk("rel_busy", 32'(ifa.busy), 32'hF);
        wait_n(6);
        chk("rel_out", 32'(ifa.req_out), 32'hF);
        k = cyc;
        ifa.req_in = 4'h0;
        for (int c = 0; c < 4; c++) push(c, 1'b0, k + 5);
        wait_n(7);

        // latency sweep and pulse mode
        for (int i = 0; i < 5; i++) begin
            ifa.cfg_dly[vt[i].ch*4 +: 4] = 4'(vt[i].dly);
            ifa.cfg_mode[vt[i].ch] = vt[i].mode;
            for (int e = 0; e < 2; e++) begin
                k = cyc;
                ifa.req_in[vt[i].ch] = (e == 0);
                if (e == 0) begin
                    push(vt[i].ch, 1'b1, k + 1 + vt[i].lat);
                    if (vt[i].pulse)
                        push(vt[i].ch, 1'b0, k + 2 + vt[i].lat);
                end else if (!vt[i].pulse) begin
                    push(vt[i].ch, 1'b0, k + 1 + vt[i].lat);
                end
                for (int j = 0; j < vt[i].lat; j++) begin
                    @(negedge clk);
                    chk($sformatf("busy_hi v%0d", i),
                        32'(ifa.busy[vt[i].ch]), 32'h1);
                end
                @(negedge clk);
                chk($sformatf("busy_lo v%0d", i),
                    32'(ifa.busy[vt[i].ch]), 32'h0);
                wait_n(vt[i].hold - vt[i].lat - 1);
            end
        end
        wait_n(3);

        // overrun on channel 2
        ifa.cfg_dly[11:8] = 4'd5;
        for (int r = 0; r < 2; r++) begin
            k = cyc;
            ifa.req_in[2] = 1'b1;
            push(2, 1'b1, k + 7);
            push(2, 1'b0, k + 13);
            wait_n(2);
            ifa.req_in[2] = 1'b0;
            if (r == 1) ifa.ovf_clr[2] = 1'b1;
            @(negedge clk);
            ifa.ovf_clr[2] = 1'b0;
            chk($sformatf("ovf_set r%0d", r), 32'(ifa.ovf), 32'h4);
            wait_n(12);
            chk($sformatf("ovf_hold r%0d", r), 32'(ifa.ovf), 32'h4);
            if (r == 0) begin
                ifa.ovf_clr[2] = 1'b1;
                @(negedge clk);
                ifa.ovf_clr[2] = 1'b0;
                chk("ovf_clr", 32'(ifa.ovf), 32'h0);
            end
        end
        ifa.ovf_clr[2] = 1'b1;
        @(negedge clk);
        ifa.ovf_clr[2] = 1'b0;

        // back-to-back on channel 3, cfg change mid-count
        ifa.cfg_dly[15:12] = 4'd2;
        k = cyc;
        ifa.req_in[3] = 1'b1;
        push(3, 1'b1, k + 4);
        push(3, 1'b0, k + 7);
        push(3, 1'b1, k + 14);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j == 3) ifa.req_in[3] = 1'b0;
            if (j == 5) ifa.cfg_dly[15:12] = 4'd6;
            if (j == 6) ifa.req_in[3] = 1'b1;
            chk($sformatf("b2b_busy j%0d", j),
                32'(ifa.busy[3]), (j < 14) ? 32'h1 : 32'h0);
        end
        chk("b2b_ovf", 32'(ifa.ovf), 32'h0);
        k = cyc;
        ifa.req_in[3] = 1'b0;
        push(3, 1'b0, k + 8);
        wait_n(10);

        // synchronised instance: latency +2, then reset mid-count
        k = cyc;
        ifb.req_in[0] = 1'b1;
        wait_n(2);
        chk("sync_busy_pre", 32'(ifb.busy), 32'h0);
        @(negedge clk);
        chk("sync_busy_det", 32'(ifb.busy), 32'h1);
        wait_n(3);
        chk("sync_out_early", 32'(ifb.req_out), 32'h0);
        @(negedge clk);
        chk("sync_out_fire", 32'(ifb.req_out), 32'h1);
        ifb.req_in[0] = 1'b0;
        wait_n(10);
        chk("sync_out_fall", 32'(ifb.req_out), 32'h0);
        ifb.req_in[0] = 1'b1;
        wait_n(4);
        chk("midrst_busy_pre", 32'(ifb.busy), 32'h1);
        rst_nb = 1'b0;
        ifb.req_in[0] = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(ifb.busy), 32'h0);
        chk("midrst_out", 32'(ifb.req_out), 32'h0);
        rst_nb = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("midrst_nofire", 32'(ifb.req_out), 32'h0);
        end

        for (int c = 0; c < 4; c++)
            chk($sformatf("sb_left ch%0d", c), 32'(q[c].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/delay_match_prog.md
# delay_match_prog

Clocked, programmable replacement for the fixed matched-delay elements in the asynchronous Booth-multiplier pipeline. Each of CH independent channels reproduces transitions of its request input on its output after a per-channel programmable number of clock cycles, in level or pulse mode. It gives FPGA builds a synthesisable, tunable delay: delay margin can be swept per stage without re-editing hard-coded simulation delays. Overrun detection flags a stage whose delay setting is too long for its request rate.

## Interface
- CH, 4: number of independent delay channels
- DW, 4: delay-setting width; per-channel setting range 0..2^DW-1
- SYNC_STAGES, 0: input synchroniser flops per channel, 0..3 (0 = inputs already synchronous to clk)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_in  in  CH  per-channel request input (level signal)
- cfg_dly  in  CH*DW  per-channel delay setting, channel i at bits [i*DW +: DW]
- cfg_mode  in  CH  per-channel mode: 0 = level, 1 = pulse
- ovf_clr  in  CH  per-channel sticky-overrun clear, one-cycle strobe
- req_out  out  CH  delayed request per channel
- busy  out  CH  channel counting a transition
- ovf  out  CH  sticky overrun flag per channel

## Operation
- Reset (rst_n low at a clock edge): req_out=0, busy=0, ovf=0; internal tracked level trk=0, counter=0, synchroniser flops=0, all channels IDLE. Reset mid-count discards the transition in flight.
- Per channel, s = req_in after SYNC_STAGES flops. Channels are fully independent.
- State IDLE (busy=0): if s != trk: trk<=s, cnt<=cfg_dly[i], mode latched<=cfg_mode[i], go COUNT. Else stay.
- State COUNT (busy=1):
  - cnt != 0: cnt<=cnt-1. If s != trk on this edge, ovf<=1 (sticky).
  - cnt == 0 (fire): level mode: req_out<=trk. Pulse mode: req_out<=1 for exactly one cycle if trk==1, else stays 0 (falling transitions count but emit nothing).
  - Fire with s != trk: back-to-back restart, trk<=s, cnt<=cfg_dly[i], latch mode, stay COUNT; no ovf set by this edge alone.
  - Fire with s == trk: go IDLE.
- Input pulses that start and end within one COUNT window are absorbed: ovf set, trk unchanged, no output transition for them.
- cfg_dly/cfg_mode sampled only when a count is loaded; changes mid-count take effect on the next transition.
- ovf_clr[i] clears ovf[i] at the next edge; simultaneous set and clear: set wins.
- Pulse-mode req_out is cleared the cycle after firing unless a back-to-back rising fire occurs (impossible: consecutive fires alternate trk).

## Timing
- Latency from first edge at which s differs from trk to req_out change: cfg_dly+1 cycles; from req_in edge add SYNC_STAGES cycles.
- cfg_dly=0: output changes on the edge after detection (minimum latency 1 cycle + SYNC_STAGES).
- busy rises on the detection edge, falls on the fire edge (unless back-to-back restart).
- Max sustainable transition rate per channel without overrun: one transition per cfg_dly+1 cycles.
- All outputs registered; no combinational path req_in -> req_out.

## Test plan
- Reset: drive req_in=4'hF, cfg_dly=all 3, hold rst_n low 5 cycles -> req_out=0, busy=0, ovf=0 throughout; after release, req_out=4'hF exactly 4 cycles after first sampling edge.
- Latency sweep, SYNC_STAGES=0, level mode: channel 0 toggle with cfg_dly=0,1,7,15 -> req_out[0] follows after 1,2,8,16 cycles; rising and falling edges equal latency.
- Pulse mode, cfg_dly=2: req_in[1] 0->1, hold 10, 1->0 -> single one-cycle req_out[1] pulse 3 cycles after rise; nothing on fall; busy high 3 cycles each transition.
- Overrun: cfg_dly=5, req_in[2] 2-cycle high pulse -> output rises after 6 cycles and stays 1 until next detected change, ovf[2]=1; ovf_clr strobe -> ovf[2]=0; simultaneous new overrun and clr -> ovf stays 1.
- Back-to-back: cfg_dly=2, req_in[3] toggles every 3 cycles -> req_out[3] toggles every 3 cycles, busy stays 1, ovf=0; change cfg_dly to 6 mid-count -> current count unaffected, next uses 6.
- SYNC_STAGES=2, reset mid-count: latency increases by exactly 2; rst_n low during COUNT -> req_out=0, busy=0 next edge, no later fire.
